// File: rtl/if_id_skid_register_pkg.sv
// Shared definitions for the IF/ID skid register: NOP encoding,
// beat payload layout and skid buffer occupancy states.
package if_id_skid_register_pkg;

    localparam int          PKG_XLEN = 32;
    localparam logic [31:0] RV_NOP   = 32'h00000013;  // addi x0,x0,0

    typedef struct packed {
        logic [PKG_XLEN-1:0] instruction;
        logic [PKG_XLEN-1:0] pc;
        logic                fault;
    } if_id_payload_t;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_payload_slot.sv
// One IF/ID payload register (instruction, pc, fault) with a load enable
// and a synchronous clear that returns the slot to the NOP/zero payload.
// Clear wins over load so a killed slot never captures new data.
module pipe_payload_slot
    import if_id_skid_register_pkg::*;
#(
    parameter int              XLEN = 32,
    parameter logic [XLEN-1:0] NOP  = XLEN'(RV_NOP)
) (
    input  logic            clk,
    input  logic            i_clear,
    input  logic            i_load,
    input  logic [XLEN-1:0] i_instruction,
    input  logic [XLEN-1:0] i_pc,
    input  logic            i_fault,
    output logic [XLEN-1:0] o_instruction,
    output logic [XLEN-1:0] o_pc,
    output logic            o_fault
);

    logic [XLEN-1:0] r_instruction;
    logic [XLEN-1:0] r_pc;
    logic            r_fault;

    // Payload storage: clear to NOP, load new beat, otherwise hold.
    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_instruction <= NOP;
            r_pc          <= {XLEN{1'b0}};
            r_fault       <= 1'b0;
        end else if (i_load) begin
            r_instruction <= i_instruction;
            r_pc          <= i_pc;
            r_fault       <= i_fault;
        end else begin
            r_instruction <= r_instruction;
            r_pc          <= r_pc;
            r_fault       <= r_fault;
        end
    end

    assign o_instruction = r_instruction;
    assign o_pc          = r_pc;
    assign o_fault       = r_fault;

endmodule

// File: rtl/if_id_skid_register.sv
// IF/ID pipeline register with valid/ready handshake and a 2-entry skid
// buffer (main slot drives decode, skid slot absorbs one beat during a
// decode stall). if_ready is registered, so there is no combinational
// path from id_ready back to fetch. Synchronous flush kills everything.
// Optional build macro: IF_ID_PERF_CNT_EN adds saturating stall/bubble
// counters as extra output ports.
module if_id_skid_register
    import if_id_skid_register_pkg::*;
#(
    parameter int              XLEN            = 32,
    parameter logic [XLEN-1:0] NOP_INSTRUCTION = XLEN'(RV_NOP),
    parameter int              ILEN_BYTES      = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    output logic            if_ready,
    input  logic [XLEN-1:0] if_instruction,
    input  logic [XLEN-1:0] if_pc,
    input  logic            if_fault,
    input  logic            id_flush,
    input  logic            id_ready,
    output logic            id_valid,
    output logic [XLEN-1:0] id_instruction,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc_plus_4,
`ifdef IF_ID_PERF_CNT_EN
    output logic [31:0]     stall_cycles,
    output logic [31:0]     bubble_cycles,
`endif
    output logic            id_fault
);

    skid_state_e     r_state;
    skid_state_e     w_next_state;
    logic            r_if_ready;

    logic            w_in_fire;
    logic            w_out_fire;
    logic            w_main_load;
    logic            w_main_clear;
    logic            w_main_from_skid;
    logic            w_skid_load;
    logic            w_skid_clear;

    logic [XLEN-1:0] w_main_instruction;
    logic [XLEN-1:0] w_main_pc;
    logic            w_main_fault;
    logic [XLEN-1:0] w_skid_instruction;
    logic [XLEN-1:0] w_skid_pc;
    logic            w_skid_fault;

    assign id_valid   = (r_state != SKID_EMPTY);
    assign w_in_fire  = if_valid & r_if_ready;
    assign w_out_fire = id_valid & id_ready;

    // Occupancy transitions and slot load/clear strobes; flush overrides all.
    always_comb begin
        w_next_state     = r_state;
        w_main_load      = 1'b0;
        w_main_clear     = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_clear     = 1'b0;
        if (id_flush) begin
            w_next_state = SKID_EMPTY;
            w_main_clear = 1'b1;
            w_skid_clear = 1'b1;
        end else begin
            case (r_state)
                SKID_EMPTY: begin
                    if (w_in_fire) begin
                        w_main_load  = 1'b1;
                        w_next_state = SKID_ONE;
                    end else begin
                        w_next_state = SKID_EMPTY;
                    end
                end
                SKID_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_main_load  = 1'b1;
                        w_next_state = SKID_ONE;
                    end else if (w_in_fire) begin
                        w_skid_load  = 1'b1;
                        w_next_state = SKID_FULL;
                    end else if (w_out_fire) begin
                        w_main_clear = 1'b1;
                        w_next_state = SKID_EMPTY;
                    end else begin
                        w_next_state = SKID_ONE;
                    end
                end
                SKID_FULL: begin
                    if (w_out_fire) begin
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_clear     = 1'b1;
                        w_next_state     = SKID_ONE;
                    end else begin
                        w_next_state = SKID_FULL;
                    end
                end
                default: begin
                    w_next_state = SKID_EMPTY;
                    w_main_clear = 1'b1;
                    w_skid_clear = 1'b1;
                end
            endcase
        end
    end

    // State and registered ready: ready drops only when both slots are occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= SKID_EMPTY;
            r_if_ready <= 1'b1;
        end else begin
            r_state    <= w_next_state;
            r_if_ready <= (w_next_state != SKID_FULL);
        end
    end

    pipe_payload_slot #(
        .XLEN (XLEN),
        .NOP  (NOP_INSTRUCTION)
    ) u_main_slot (
        .clk           (clk),
        .i_clear       (rst | w_main_clear),
        .i_load        (w_main_load),
        .i_instruction (w_main_from_skid ? w_skid_instruction : if_instruction),
        .i_pc          (w_main_from_skid ? w_skid_pc : if_pc),
        .i_fault       (w_main_from_skid ? w_skid_fault : if_fault),
        .o_instruction (w_main_instruction),
        .o_pc          (w_main_pc),
        .o_fault       (w_main_fault)
    );

    pipe_payload_slot #(
        .XLEN (XLEN),
        .NOP  (NOP_INSTRUCTION)
    ) u_skid_slot (
        .clk           (clk),
        .i_clear       (rst | w_skid_clear),
        .i_load        (w_skid_load),
        .i_instruction (if_instruction),
        .i_pc          (if_pc),
        .i_fault       (if_fault),
        .o_instruction (w_skid_instruction),
        .o_pc          (w_skid_pc),
        .o_fault       (w_skid_fault)
    );

    // Main slot is cleared whenever it empties, so it already reads NOP/0.
    assign if_ready       = r_if_ready;
    assign id_instruction = w_main_instruction;
    assign id_pc          = w_main_pc;
    assign id_fault       = w_main_fault;
    assign id_pc_plus_4   = w_main_pc + XLEN'(ILEN_BYTES);

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_bubble_cycles;

    // Saturating stall/bubble counters; cleared by reset only, not by flush.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cycles  <= 32'd0;
            r_bubble_cycles <= 32'd0;
        end else begin
            if (id_valid && !id_ready && (r_stall_cycles != 32'hFFFF_FFFF)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end else begin
                r_stall_cycles <= r_stall_cycles;
            end
            if (!id_valid && !id_flush && (r_bubble_cycles != 32'hFFFF_FFFF)) begin
                r_bubble_cycles <= r_bubble_cycles + 32'd1;
            end else begin
                r_bubble_cycles <= r_bubble_cycles;
            end
        end
    end

    assign stall_cycles  = r_stall_cycles;
    assign bubble_cycles = r_bubble_cycles;
`endif

endmodule

// File: tb/tb_if_id_skid_register.sv
// Directed self-checking bench for if_id_skid_register. Inputs are driven
// 1 time unit after each rising edge; outputs are checked at that point.
`timescale 1ns/1ps
module tb_if_id_skid_register;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_instruction = 32'd0;
    logic [31:0] if_pc = 32'd0;
    logic        if_fault = 1'b0;
    logic        id_flush = 1'b0;
    logic        id_ready = 1'b0;
    logic        id_valid;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus_4;
    logic        id_fault;
`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cycles;
    logic [31:0] bubble_cycles;
`endif

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    if_id_skid_register dut (
        .clk            (clk),
        .rst            (rst),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instruction (if_instruction),
        .if_pc          (if_pc),
        .if_fault       (if_fault),
        .id_flush       (id_flush),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instruction (id_instruction),
        .id_pc          (id_pc),
        .id_pc_plus_4   (id_pc_plus_4),
`ifdef IF_ID_PERF_CNT_EN
        .stall_cycles   (stall_cycles),
        .bubble_cycles  (bubble_cycles),
`endif
        .id_fault       (id_fault)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                         input logic flt, input logic rdy, input logic fl);
        if_valid       = v;
        if_instruction = instr;
        if_pc          = pc;
        if_fault       = flt;
        id_ready       = rdy;
        id_flush       = fl;
    endtask

    task automatic test_reset();
        logic [97:0] exp_v;
        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        exp_v = {1'b1, 1'b0, NOP, 32'd0, 32'd4};
        n_total++;
        if ({if_ready, id_valid, id_instruction, id_pc, id_pc_plus_4} !== exp_v)
            $display("FAIL reset_outputs got=%h exp=%h", {if_ready, id_valid, id_instruction, id_pc, id_pc_plus_4}, exp_v);
        else n_pass++;
        n_total++;
        if (id_fault !== 1'b0) $display("FAIL reset_fault got=%b exp=0", id_fault);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] pcs [3];
        rst = 1'b0;
        pcs[0] = 32'h100; pcs[1] = 32'h104; pcs[2] = 32'h108;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'hA000_0000 + pcs[i], pcs[i], 1'b0, 1'b1, 1'b0);
            step();
            n_total++;
            if ({id_valid, id_instruction, id_pc, id_pc_plus_4} !== {1'b1, 32'hA000_0000 + pcs[i], pcs[i], pcs[i] + 32'd4})
                $display("FAIL stream_beat%0d got v=%b i=%h pc=%h pc4=%h exp pc=%h", i, id_valid, id_instruction, id_pc, id_pc_plus_4, pcs[i]);
            else n_pass++;
        end
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        step();
        n_total++;
        if ({id_valid, id_instruction, id_pc} !== {1'b0, NOP, 32'd0})
            $display("FAIL stream_drain got v=%b i=%h pc=%h exp v=0 i=%h pc=0", id_valid, id_instruction, id_pc, NOP);
        else n_pass++;
    endtask

    task automatic test_stall();
        drive(1'b1, 32'hB200, 32'h200, 1'b0, 1'b1, 1'b0);
        step();
        drive(1'b1, 32'hB204, 32'h204, 1'b0, 1'b0, 1'b0);
        step();
        n_total++;
        if ({if_ready, id_valid, id_pc} !== {1'b0, 1'b1, 32'h200})
            $display("FAIL stall_full got rdy=%b v=%b pc=%h exp rdy=0 v=1 pc=200", if_ready, id_valid, id_pc);
        else n_pass++;
        // Offered beat while full must be ignored.
        drive(1'b1, 32'hB208, 32'h208, 1'b0, 1'b0, 1'b0);
        step();
        n_total++;
        if ({if_ready, id_pc, id_instruction} !== {1'b0, 32'h200, 32'hB200})
            $display("FAIL stall_hold got rdy=%b pc=%h i=%h exp rdy=0 pc=200 i=B200", if_ready, id_pc, id_instruction);
        else n_pass++;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        step();
        n_total++;
        if ({if_ready, id_valid, id_pc, id_instruction} !== {1'b1, 1'b1, 32'h204, 32'hB204})
            $display("FAIL stall_release got rdy=%b v=%b pc=%h i=%h exp rdy=1 v=1 pc=204", if_ready, id_valid, id_pc, id_instruction);
        else n_pass++;
        step();
        n_total++;
        if (id_valid !== 1'b0) $display("FAIL stall_no_dup got v=%b pc=%h exp v=0", id_valid, id_pc);
        else n_pass++;
    endtask

    task automatic test_flush();
        drive(1'b1, 32'hC300, 32'h300, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hC304, 32'h304, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hC308, 32'h308, 1'b0, 1'b0, 1'b1);
        step();
        n_total++;
        if ({if_ready, id_valid, id_instruction, id_pc} !== {1'b1, 1'b0, NOP, 32'd0})
            $display("FAIL flush_full got rdy=%b v=%b i=%h pc=%h exp rdy=1 v=0 i=%h pc=0", if_ready, id_valid, id_instruction, id_pc, NOP);
        else n_pass++;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        step();
        n_total++;
        if (id_valid !== 1'b0) $display("FAIL flush_full_gone got v=%b pc=%h exp v=0", id_valid, id_pc);
        else n_pass++;
        // Flush in ONE while a beat is accepted: the incoming beat is dropped too.
        drive(1'b1, 32'hC310, 32'h310, 1'b0, 1'b0, 1'b0);
        step();
        drive(1'b1, 32'hC314, 32'h314, 1'b0, 1'b0, 1'b1);
        step();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        step();
        n_total++;
        if ({id_valid, id_pc} !== {1'b0, 32'd0})
            $display("FAIL flush_one_incoming got v=%b pc=%h exp v=0 pc=0", id_valid, id_pc);
        else n_pass++;
    endtask

    task automatic test_rst_flush();
        drive(1'b1, 32'hD400, 32'h400, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        drive(1'b1, 32'hD404, 32'h404, 1'b1, 1'b0, 1'b1);
        step();
        n_total++;
        if ({if_ready, id_valid, id_instruction, id_pc, id_pc_plus_4, id_fault} !== {1'b1, 1'b0, NOP, 32'd0, 32'd4, 1'b0})
            $display("FAIL rst_flush_prio got rdy=%b v=%b i=%h pc=%h pc4=%h f=%b", if_ready, id_valid, id_instruction, id_pc, id_pc_plus_4, id_fault);
        else n_pass++;
        rst = 1'b0;
        drive(1'b1, 32'hD408, 32'h408, 1'b0, 1'b1, 1'b0);
        step();
        n_total++;
        if ({id_valid, id_pc, id_instruction} !== {1'b1, 32'h408, 32'hD408})
            $display("FAIL rst_flush_next got v=%b pc=%h i=%h exp v=1 pc=408 i=D408", id_valid, id_pc, id_instruction);
        else n_pass++;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        step();
    endtask

    task automatic test_wrap_fault();
        drive(1'b1, 32'hDEADBEEF, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0);
        step();
        n_total++;
        if ({id_valid, id_pc, id_pc_plus_4, id_fault, id_instruction} !== {1'b1, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'hDEADBEEF})
            $display("FAIL wrap_fault got v=%b pc=%h pc4=%h f=%b i=%h exp pc4=0 f=1 i=DEADBEEF", id_valid, id_pc, id_pc_plus_4, id_fault, id_instruction);
        else n_pass++;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        step();
        n_total++;
        if ({id_valid, id_fault, id_pc_plus_4} !== {1'b0, 1'b0, 32'd4})
            $display("FAIL wrap_drain got v=%b f=%b pc4=%h exp v=0 f=0 pc4=4", id_valid, id_fault, id_pc_plus_4);
        else n_pass++;
    endtask

`ifdef IF_ID_PERF_CNT_EN
    task automatic test_perf();
        rst = 1'b1;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        step();
        rst = 1'b0;
        drive(1'b1, 32'hE500, 32'h500, 1'b0, 1'b0, 1'b0);
        step();                                   // empty cycle: bubble=1
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) step();       // stall=5
        id_ready = 1'b1;
        step();                                   // consumed, no count
        step();
        step();                                   // bubble=3
        n_total++;
        if ({stall_cycles, bubble_cycles} !== {32'd5, 32'd3})
            $display("FAIL perf_counts got stall=%0d bubble=%0d exp stall=5 bubble=3", stall_cycles, bubble_cycles);
        else n_pass++;
        id_flush = 1'b1;
        step();
        id_flush = 1'b0;
        n_total++;
        if ({stall_cycles, bubble_cycles} !== {32'd5, 32'd3})
            $display("FAIL perf_flush got stall=%0d bubble=%0d exp stall=5 bubble=3", stall_cycles, bubble_cycles);
        else n_pass++;
    endtask
`endif

    initial begin
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_rst_flush();
        test_wrap_fault();
`ifdef IF_ID_PERF_CNT_EN
        test_perf();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
